pdp_core_preproc: RTL and testbench

Input pre-processor for the PDP core, directly downstream of the NaN pre-processing stage. It selects the datapath source by flying mode:
- **Off-line:** RDMA data arrives via the NaN stage, already formatted, and passes through.
- **On-the-fly:** SDP delivers one int8 element per beat. The block packs these into 4-element beats and generates position/end flags.

The result goes through a single output register stage to the 1D pooling (cal1d) stage.

---
 rtl/pdp_core_preproc.sv | 166 ++++++++++++++++
 tb/tb_pdp_core_preproc.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp_core_preproc.sv
// PDP core input pre-processor.
// Picks the datapath source by flying mode and feeds the 1D pooling stage through a single
// output register.
//   - Off-line (reg2dp_flying_mode=1): 46-bit NaN-stage beats pass through unchanged.
//   - On-the-fly (reg2dp_flying_mode=0): int8 SDP elements are packed four per beat. Each beat
//     gets line/surface/split/cube end flags in info bits [45:32].
// Ports:
//   nvdla_core_clk, nvdla_core_rstn       clock, async active-low reset
//   reg2dp_*                              layer configuration (cube sizes are minus-1)
//   nan_preproc_pd/pvld/prdy              off-line input handshake
//   sdp2pdp_pd/valid/ready                on-the-fly input handshake
//   pre2cal1d_pd/pvld/prdy                output handshake
module pdp_core_preproc (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        reg2dp_flying_mode,
  input  logic        reg2dp_op_en,
  input  logic [12:0] reg2dp_cube_in_width,
  input  logic [12:0] reg2dp_cube_in_height,
  input  logic [12:0] reg2dp_cube_in_channel,
  input  logic [45:0] nan_preproc_pd,
  input  logic        nan_preproc_pvld,
  output logic        nan_preproc_prdy,
  input  logic [7:0]  sdp2pdp_pd,
  input  logic        sdp2pdp_valid,
  output logic        sdp2pdp_ready,
  output logic [45:0] pre2cal1d_pd,
  output logic        pre2cal1d_pvld,
  input  logic        pre2cal1d_prdy
);

  logic [45:0] out_pd_q, out_pd_d;
  logic        out_vld_q, out_vld_d;
  logic [1:0]  e_cnt_q, e_cnt_d;
  logic [12:0] w_cnt_q, w_cnt_d;
  logic [12:0] h_cnt_q, h_cnt_d;
  logic [10:0] s_cnt_q, s_cnt_d;
  logic [23:0] pack_q, pack_d;
  logic        op_en_q;

  logic        out_accept;
  logic        off_acc;
  logic        sdp_acc;
  logic        op_en_rise;
  logic        last_surf;
  logic        beat_done;
  logic        line_end;
  logic        surf_end;
  logic        cube_end;
  logic        sdp_load;
  logic [31:0] beat_data;
  logic [13:0] beat_info;

  // Ready depends only on output register state and prdy, never on an input valid.
  assign out_accept       = ~out_vld_q | pre2cal1d_prdy;
  assign nan_preproc_prdy = reg2dp_flying_mode & out_accept;
  assign sdp2pdp_ready    = ~reg2dp_flying_mode & out_accept;

  assign off_acc    = nan_preproc_pvld & nan_preproc_prdy;
  assign sdp_acc    = sdp2pdp_valid & sdp2pdp_ready;
  assign op_en_rise = reg2dp_op_en & ~op_en_q;

  // The last surface only carries channel[1:0]+1 elements; the rest of its beat is zero.
  assign last_surf = (s_cnt_q == reg2dp_cube_in_channel[12:2]);
  assign beat_done = last_surf ? (e_cnt_q == reg2dp_cube_in_channel[1:0]) : (e_cnt_q == 2'd3);
  assign line_end  = (w_cnt_q == reg2dp_cube_in_width);
  assign surf_end  = line_end & (h_cnt_q == reg2dp_cube_in_height);
  assign cube_end  = surf_end & last_surf;

  // A clear coinciding with an accept drops the element, so it must not load the output.
  assign sdp_load = sdp_acc & beat_done & ~op_en_rise;

  always_comb begin
    // Pack buffer slots above e_cnt are already zero, which gives the padding.
    beat_data = {8'h00, pack_q};
    beat_data[{e_cnt_q, 3'b000} +: 8] = sdp2pdp_pd;
    beat_info     = '0;
    beat_info[0]  = line_end;
    beat_info[1]  = surf_end;
    beat_info[9]  = cube_end;  // split_end
    beat_info[13] = cube_end;
  end

  always_comb begin
    out_pd_d  = out_pd_q;
    out_vld_d = out_vld_q;
    if (off_acc) begin
      out_pd_d  = nan_preproc_pd;
      out_vld_d = 1'b1;
    end else if (sdp_load) begin
      out_pd_d  = {beat_info, beat_data};
      out_vld_d = 1'b1;
    end else if (pre2cal1d_prdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_comb begin
    e_cnt_d = e_cnt_q;
    w_cnt_d = w_cnt_q;
    h_cnt_d = h_cnt_q;
    s_cnt_d = s_cnt_q;
    pack_d  = pack_q;
    if (op_en_rise) begin
      e_cnt_d = '0;
      w_cnt_d = '0;
      h_cnt_d = '0;
      s_cnt_d = '0;
      pack_d  = '0;
    end else if (sdp_acc) begin
      if (beat_done) begin
        e_cnt_d = '0;
        pack_d  = '0;
        if (cube_end) begin
          w_cnt_d = '0;
          h_cnt_d = '0;
          s_cnt_d = '0;
        end else if (line_end) begin
          w_cnt_d = '0;
          if (surf_end) begin
            h_cnt_d = '0;
            s_cnt_d = s_cnt_q + 11'd1;
          end else begin
            h_cnt_d = h_cnt_q + 13'd1;
          end
        end else begin
          w_cnt_d = w_cnt_q + 13'd1;
        end
      end else begin
        e_cnt_d = e_cnt_q + 2'd1;
        case (e_cnt_q)
          2'd0:    pack_d[7:0]   = sdp2pdp_pd;
          2'd1:    pack_d[15:8]  = sdp2pdp_pd;
          2'd2:    pack_d[23:16] = sdp2pdp_pd;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_pd_q  <= '0;
      out_vld_q <= 1'b0;
      e_cnt_q   <= '0;
      w_cnt_q   <= '0;
      h_cnt_q   <= '0;
      s_cnt_q   <= '0;
      pack_q    <= '0;
      op_en_q   <= 1'b0;
    end else begin
      out_pd_q  <= out_pd_d;
      out_vld_q <= out_vld_d;
      e_cnt_q   <= e_cnt_d;
      w_cnt_q   <= w_cnt_d;
      h_cnt_q   <= h_cnt_d;
      s_cnt_q   <= s_cnt_d;
      pack_q    <= pack_d;
      op_en_q   <= reg2dp_op_en;
    end
  end

  assign pre2cal1d_pd   = out_pd_q;
  assign pre2cal1d_pvld = out_vld_q;

endmodule

// File: tb/tb_pdp_core_preproc.sv
`timescale 1ns/1ps
module tb_pdp_core_preproc;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flying;
  logic        op_en;
  logic [12:0] width, height, channel;
  logic [45:0] nan_pd;
  logic        nan_pvld;
  logic        nan_prdy;
  logic [7:0]  sdp_pd;
  logic        sdp_valid;
  logic        sdp_ready;
  logic [45:0] out_pd;
  logic        out_pvld;
  logic        out_prdy;

  int checks = 0;
  int errors = 0;
  logic [7:0]  sdp_q[$];
  logic [45:0] exp_q[$];
  bit          rand_rdy = 1'b0;
  bit          sdp_busy = 1'b0;

  pdp_core_preproc dut (
    .nvdla_core_clk         (clk),
    .nvdla_core_rstn        (rstn),
    .reg2dp_flying_mode     (flying),
    .reg2dp_op_en           (op_en),
    .reg2dp_cube_in_width   (width),
    .reg2dp_cube_in_height  (height),
    .reg2dp_cube_in_channel (channel),
    .nan_preproc_pd         (nan_pd),
    .nan_preproc_pvld       (nan_pvld),
    .nan_preproc_prdy       (nan_prdy),
    .sdp2pdp_pd             (sdp_pd),
    .sdp2pdp_valid          (sdp_valid),
    .sdp2pdp_ready          (sdp_ready),
    .pre2cal1d_pd           (out_pd),
    .pre2cal1d_pvld         (out_pvld),
    .pre2cal1d_prdy         (out_prdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every output transfer is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn && out_pvld && out_prdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%0h required=none", out_pd);
      end else begin
        check("beat", {18'h0, out_pd}, {18'h0, exp_q.pop_front()});
      end
    end
  end

  // Random output back-pressure.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_prdy = ($urandom_range(0, 3) != 0);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_op_en();
    op_en = 1'b0;
    cycle();
    op_en = 1'b1;
    cycle();
  endtask

  // Reference model: walks the cube surface by surface, row by row, pixel by pixel, drawing
  // each pixel's channel group from the element stream and forming the expected beat.
  task automatic layer(input int w, input int h, input int c, input bit seq, input int start);
    int          val;
    int          n;
    logic [7:0]  b;
    logic [31:0] data;
    bit          le, se, ce;
    val     = start;
    width   = 13'(w);
    height  = 13'(h);
    channel = 13'(c);
    for (int s = 0; s <= c / 4; s++) begin
      for (int hh = 0; hh <= h; hh++) begin
        for (int ww = 0; ww <= w; ww++) begin
          n    = (s == c / 4) ? (c % 4) + 1 : 4;
          data = '0;
          for (int k = 0; k < n; k++) begin
            b = seq ? 8'(val) : 8'($urandom);
            val++;
            sdp_q.push_back(b);
            data[8*k +: 8] = b;
          end
          le = (ww == w);
          se = le && (hh == h);
          ce = se && (s == c / 4);
          exp_q.push_back({ce, 3'b000, ce, 7'b0000000, se, le, data});
        end
      end
    end
  endtask

  task automatic run_sdp();
    int guard;
    sdp_busy = 1'b1;
    while (sdp_q.size() > 0) begin
      if ($urandom_range(0, 3) == 0) begin
        sdp_valid = 1'b0;
        cycle();
      end
      sdp_valid = 1'b1;
      sdp_pd    = sdp_q[0];
      guard     = 0;
      @(negedge clk);
      while (!sdp_ready && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (!sdp_ready) begin
        fail_now("sdp_handshake_timeout");
        sdp_q.delete();
      end else begin
        void'(sdp_q.pop_front());
      end
      cycle();
    end
    sdp_valid = 1'b0;
    sdp_busy  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || sdp_busy) && guard < 3000) begin
      cycle();
      guard++;
    end
    if (exp_q.size() != 0 || sdp_busy) begin
      fail_now(name);
      exp_q.delete();
    end
    cycle();
  endtask

  initial begin
    int          guard;
    logic [45:0] held;
    logic [45:0] v;
    rstn = 1'b0; flying = 1'b0; op_en = 1'b0;
    width = '0; height = '0; channel = '0;
    nan_pd = '0; nan_pvld = 1'b0; sdp_pd = '0; sdp_valid = 1'b0; out_prdy = 1'b0;

    // Reset state
    #12;
    check("rst_pvld", 64'(out_pvld), 64'd0);
    check("rst_pd", 64'(out_pd), 64'd0);
    check("rst_sdp_ready", 64'(sdp_ready), 64'd1);
    check("rst_nan_prdy", 64'(nan_prdy), 64'd0);
    cycle();
    rstn = 1'b1;
    cycle();

    // Off-line pass-through with one-cycle latency
    flying = 1'b1;
    out_prdy = 1'b1;
    exp_q.push_back(46'h2A_1234_5678);
    nan_pd = 46'h2A_1234_5678;
    nan_pvld = 1'b1;
    #1;
    check("off_sdp_ready", 64'(sdp_ready), 64'd0);
    check("off_nan_prdy", 64'(nan_prdy), 64'd1);
    cycle();
    nan_pvld = 1'b0;
    check("off_latency_pvld", 64'(out_pvld), 64'd1);
    check("off_latency_pd", 64'(out_pd), 64'h2A_1234_5678);
    wait_drain("off_drain_timeout");

    // Off-line random beats under random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      v = {14'($urandom), 32'($urandom)};
      exp_q.push_back(v);
      nan_pd = v;
      nan_pvld = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!nan_prdy && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (!nan_prdy) fail_now("nan_handshake_timeout");
      cycle();
    end
    nan_pvld = 1'b0;
    wait_drain("off_rand_drain_timeout");

    // Mode isolation
    rand_rdy = 1'b0;
    out_prdy = 1'b1;
    sdp_pd = 8'h5A;
    sdp_valid = 1'b1;
    #1;
    check("iso_sdp_ready", 64'(sdp_ready), 64'd0);
    cycle();
    sdp_valid = 1'b0;
    flying = 1'b0;
    nan_pvld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("iso_nan_prdy", 64'(nan_prdy), 64'd0);
      check("iso_no_output", 64'(out_pvld), 64'd0);
    end
    cycle();
    nan_pvld = 1'b0;

    // On-the-fly pack, full groups
    layer(1, 0, 3, 1'b1, 1);
    pulse_op_en();
    run_sdp();
    wait_drain("pack_drain_timeout");

    // Partial last group
    layer(0, 0, 5, 1'b1, 1);
    pulse_op_en();
    run_sdp();
    wait_drain("partial_drain_timeout");

    // Back-pressure: hold prdy low while a beat is valid
    layer(1, 0, 3, 1'b1, 1);
    pulse_op_en();
    out_prdy = 1'b0;
    fork
      run_sdp();
    join_none
    guard = 0;
    @(negedge clk);
    while (!out_pvld && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!out_pvld) fail_now("bp_valid_timeout");
    held = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_pd_stable", 64'(out_pd), 64'(held));
      check("bp_sdp_ready", 64'(sdp_ready), 64'd0);
    end
    cycle();
    out_prdy = 1'b1;
    wait_drain("bp_drain_timeout");

    // op_en restart: two stray elements, then a clear; one more dropped by a coincident clear
    width = 13'd1; height = 13'd0; channel = 13'd3;
    pulse_op_en();
    sdp_q.push_back(8'hA1);
    sdp_q.push_back(8'hA2);
    run_sdp();
    op_en = 1'b0;
    cycle();
    op_en = 1'b1;
    sdp_pd = 8'hEE;
    sdp_valid = 1'b1;
    cycle();
    sdp_valid = 1'b0;
    layer(1, 0, 3, 1'b1, 8'h11);
    run_sdp();
    wait_drain("restart_drain_timeout");

    // Random layers under random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      layer($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 9), 1'b0, 0);
      pulse_op_en();
      run_sdp();
      wait_drain("rand_drain_timeout");
    end
    rand_rdy = 1'b0;
    out_prdy = 1'b1;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
